decode_stage: RTL
=================

Name: decode_stage

Overview:
RV32I decode stage. It sits between the fetch-to-decode pipeline register and the execute stage.
- Decodes the instruction and generates the sign-extended immediate.
- Holds the 32x32 integer register file, written from writeback.
- Registers all operands, control and prediction metadata into the decode-to-execute pipeline register, with stall and flush support.
- Exposes the decode-side source addresses combinationally to the hazard unit.

Parameters:
DATA_W, 32, datapath and register width
NUM_REGS, 32, register file depth; x0 hardwired to zero

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_stall_e  in  1  hold the D/E register
i_flush_e  in  1  load a bubble into the D/E register
i_instr_d  in  32  instruction from fetch
i_pc_d  in  32  PC of instruction
i_pc_four_d  in  32  PC+4
i_taken_d  in  1  fetch predicted taken
i_predicted_pc_d  in  32  fetch predicted target
i_wr_en_w  in  1  writeback enable
i_rd_w  in  5  writeback destination
i_wb_data_w  in  32  writeback data
o_rs1_addr_d  out  5  instr[19:15], combinational, for the hazard unit
o_rs2_addr_d  out  5  instr[24:20], combinational
o_rs1_data_e, o_rs2_data_e  out  32 each  registered operands
o_imm_e  out  32  registered immediate
o_rs1_addr_e, o_rs2_addr_e, o_rd_e  out  5 each  registered addresses
o_pc_e, o_pc_four_e, o_predicted_pc_e  out  32 each  passthrough
o_taken_e  out  1  passthrough
o_funct3_e  out  3  branch/load/store subtype
o_alu_op_e  out  4  ALU operation
o_op_a_sel_e  out  1  0=rs1, 1=PC
o_op_b_sel_e  out  1  0=rs2, 1=imm
o_wb_sel_e  out  2  0=ALU, 1=MEM, 2=PC+4
o_reg_wr_en_e, o_mem_rd_en_e, o_mem_wr_en_e  out  1 each
o_is_branch_e, o_is_jump_e  out  1 each
o_illegal_e  out  1  unrecognised opcode

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All 32 registers clear to 0.
  - Every registered output clears to 0.
  - Reset overrides all other inputs, including a writeback in the same cycle.
- Register file:
  - Write on the rising edge when i_wr_en_w=1 and i_rd_w!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Writes happen regardless of stall or flush.
- Write-through bypass: if i_wr_en_w=1, i_rd_w!=0 and i_rd_w equals rs1 (or rs2), that read returns i_wb_data_w in the same cycle.
- D/E register priority: reset > stall (hold all outputs) > flush (bubble) > load decoded values.
  - Latency: 1 cycle from decode inputs to the *_e outputs.
- Bubble contents: all registered outputs 0, i.e. no enables asserted and o_illegal_e=0.
- An all-zero i_instr_d (fetch flush bubble) decodes as a bubble, not as illegal.
- Immediates are formed from instr and sign-extended from bit 31:
  - I: loads, OP-IMM, JALR
  - S: stores
  - B: branches, bit 0 = 0
  - U: LUI, AUIPC; imm[11:0] = 0
  - J: JAL, bit 0 = 0
  - R-type: immediate is 0.
- o_alu_op_e encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - R-type: SUB and SRA selected by instr[30].
  - OP-IMM: SRAI selected by instr[30]; SUB is never produced.
  - Loads, stores, branches, JAL, JALR, AUIPC: ADD.
  - LUI: PASS_B.
- Control decode per opcode:
  - R (0110011): wr, a=rs1, b=rs2, wb=ALU
  - OP-IMM (0010011): wr, b=imm, wb=ALU
  - LOAD (0000011): wr, mem_rd, b=imm, wb=MEM
  - STORE (0100011): mem_wr, b=imm
  - BRANCH (1100011): is_branch, a=PC, b=imm
  - JAL (1101111): wr, is_jump, a=PC, b=imm, wb=PC+4
  - JALR (1100111): wr, is_jump, a=rs1, b=imm, wb=PC+4
  - LUI (0110111): wr, b=imm, wb=ALU
  - AUIPC (0010111): wr, a=PC, b=imm, wb=ALU
- Any other non-zero opcode: o_illegal_e=1 and all enables 0.
- o_reg_wr_en_e is forced to 0 when rd=0.

Test Plan:
- Reset with i_instr_d=0x00500093 applied -> first rising edge after reset release registers rd_e=1, imm_e=5, alu_op=ADD, op_b_sel=1, reg_wr_en=1; all *_e outputs read 0 while reset is held.
- Write x5=0xDEADBEEF via writeback; then decode ADD x3,x5,x0 (0x000281B3) -> rs1_data_e=0xDEADBEEF, rs2_data_e=0.
- Same-cycle write x7=0x12345678 while decoding 0x00038133 (rs1=x7) -> rs1_data_e=0x12345678 via the bypass.
- Decode BEQ with imm -8 (0xFE000CE3) -> imm_e=0xFFFFFFF8, is_branch=1, op_a_sel=1, reg_wr_en=0.
- i_stall_e=1 for 2 cycles -> *_e outputs unchanged.
- i_flush_e=1 with i_stall_e=0 -> all *_e outputs 0.
- i_stall_e and i_flush_e both 1 -> outputs hold (stall wins).
- Write x0=0xFFFFFFFF, then read x0 -> 0.
- Opcode 0x7F -> illegal_e=1 and all enables 0.
- i_instr_d=0 -> illegal_e=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation, 32x32 register
// file with write-through bypass, and the decode-to-execute pipeline register.
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall_e,
  input  logic              i_flush_e,
  input  logic [31:0]       i_instr_d,
  input  logic [31:0]       i_pc_d,
  input  logic [31:0]       i_pc_four_d,
  input  logic              i_taken_d,
  input  logic [31:0]       i_predicted_pc_d,
  input  logic              i_wr_en_w,
  input  logic [4:0]        i_rd_w,
  input  logic [DATA_W-1:0] i_wb_data_w,
  output logic [4:0]        o_rs1_addr_d,
  output logic [4:0]        o_rs2_addr_d,
  output logic [DATA_W-1:0] o_rs1_data_e,
  output logic [DATA_W-1:0] o_rs2_data_e,
  output logic [31:0]       o_imm_e,
  output logic [4:0]        o_rs1_addr_e,
  output logic [4:0]        o_rs2_addr_e,
  output logic [4:0]        o_rd_e,
  output logic [31:0]       o_pc_e,
  output logic [31:0]       o_pc_four_e,
  output logic [31:0]       o_predicted_pc_e,
  output logic              o_taken_e,
  output logic [2:0]        o_funct3_e,
  output logic [3:0]        o_alu_op_e,
  output logic              o_op_a_sel_e,
  output logic              o_op_b_sel_e,
  output logic [1:0]        o_wb_sel_e,
  output logic              o_reg_wr_en_e,
  output logic              o_mem_rd_en_e,
  output logic              o_mem_wr_en_e,
  output logic              o_is_branch_e,
  output logic              o_is_jump_e,
  output logic              o_illegal_e
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [31:0]       imm;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd;
    logic [31:0]       pc;
    logic [31:0]       pc_four;
    logic [31:0]       predicted_pc;
    logic              taken;
    logic [2:0]        funct3;
    logic [3:0]        alu_op;
    logic              op_a_sel;
    logic              op_b_sel;
    logic [1:0]        wb_sel;
    logic              reg_wr_en;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic              is_branch;
    logic              is_jump;
    logic              illegal;
  } de_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_addr;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = i_instr_d[6:0];
  assign rd_addr   = i_instr_d[11:7];
  assign funct3    = i_instr_d[14:12];
  assign rs1_addr  = i_instr_d[19:15];
  assign rs2_addr  = i_instr_d[24:20];
  assign funct7_b5 = i_instr_d[30];

  assign o_rs1_addr_d = rs1_addr;
  assign o_rs2_addr_d = rs2_addr;

  // Register file: one write-select line per entry, x0 never selected
  logic [DATA_W-1:0]   rf_reg [NUM_REGS];
  logic [NUM_REGS-1:0] rf_we;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_rf_we
      if (gi == 0) begin : g_zero
        assign rf_we[gi] = 1'b0;
      end else begin : g_entry
        assign rf_we[gi] = i_wr_en_w && (i_rd_w == 5'(gi));
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf_we[i]) begin
          rf_reg[i] <= i_wb_data_w;
        end
      end
    end
  end

  // Reads see a same-cycle writeback so the pipeline needs no extra WB->D forward
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  always_comb begin
    rs1_data = rf_reg[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (i_wr_en_w && (i_rd_w == rs1_addr)) begin
      rs1_data = i_wb_data_w;
    end
  end

  always_comb begin
    rs2_data = rf_reg[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (i_wr_en_w && (i_rd_w == rs2_addr)) begin
      rs2_data = i_wb_data_w;
    end
  end

  // Immediate formats, all sign-extended from instr[31]
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{i_instr_d[31]}}, i_instr_d[31:20]};
  assign imm_s = {{20{i_instr_d[31]}}, i_instr_d[31:25], i_instr_d[11:7]};
  assign imm_b = {{19{i_instr_d[31]}}, i_instr_d[31], i_instr_d[7],
                  i_instr_d[30:25], i_instr_d[11:8], 1'b0};
  assign imm_u = {i_instr_d[31:12], 12'b0};
  assign imm_j = {{11{i_instr_d[31]}}, i_instr_d[31], i_instr_d[19:12],
                  i_instr_d[20], i_instr_d[30:21], 1'b0};

  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                       input logic allow_sub);
    alu_op_t op;
    case (f3)
      3'd0:    op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Control decode
  logic [31:0] imm_d;
  alu_op_t     alu_op_d;
  logic        op_a_sel_d;
  logic        op_b_sel_d;
  logic [1:0]  wb_sel_d;
  logic        reg_wr_en_d;
  logic        mem_rd_en_d;
  logic        mem_wr_en_d;
  logic        is_branch_d;
  logic        is_jump_d;
  logic        illegal_d;

  always_comb begin
    imm_d       = '0;
    alu_op_d    = ALU_ADD;
    op_a_sel_d  = 1'b0;
    op_b_sel_d  = 1'b0;
    wb_sel_d    = WB_ALU;
    reg_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    is_branch_d = 1'b0;
    is_jump_d   = 1'b0;
    illegal_d   = 1'b0;

    // An all-zero word is the fetch-side bubble and decodes to nothing
    if (i_instr_d != 32'd0) begin
      case (opcode)
        OPC_OP: begin
          reg_wr_en_d = 1'b1;
          alu_op_d    = arith_op(funct3, funct7_b5, 1'b1);
        end
        OPC_OP_IMM: begin
          reg_wr_en_d = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_i;
          alu_op_d    = arith_op(funct3, funct7_b5, 1'b0);
        end
        OPC_LOAD: begin
          reg_wr_en_d = 1'b1;
          mem_rd_en_d = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_i;
          wb_sel_d    = WB_MEM;
        end
        OPC_STORE: begin
          mem_wr_en_d = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_s;
        end
        OPC_BRANCH: begin
          is_branch_d = 1'b1;
          op_a_sel_d  = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_b;
        end
        OPC_JAL: begin
          reg_wr_en_d = 1'b1;
          is_jump_d   = 1'b1;
          op_a_sel_d  = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_j;
          wb_sel_d    = WB_PC4;
        end
        OPC_JALR: begin
          reg_wr_en_d = 1'b1;
          is_jump_d   = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_i;
          wb_sel_d    = WB_PC4;
        end
        OPC_LUI: begin
          reg_wr_en_d = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_u;
          alu_op_d    = ALU_PASS_B;
        end
        OPC_AUIPC: begin
          reg_wr_en_d = 1'b1;
          op_a_sel_d  = 1'b1;
          op_b_sel_d  = 1'b1;
          imm_d       = imm_u;
        end
        default: begin
          illegal_d = 1'b1;
        end
      endcase
    end

    if (rd_addr == 5'd0) begin
      reg_wr_en_d = 1'b0;
    end
  end

  // Decode-to-execute pipeline register
  de_t de_reg;
  de_t de_next;

  always_comb begin
    de_next              = '0;
    de_next.rs1_data     = rs1_data;
    de_next.rs2_data     = rs2_data;
    de_next.imm          = imm_d;
    de_next.rs1_addr     = rs1_addr;
    de_next.rs2_addr     = rs2_addr;
    de_next.rd           = rd_addr;
    de_next.pc           = i_pc_d;
    de_next.pc_four      = i_pc_four_d;
    de_next.predicted_pc = i_predicted_pc_d;
    de_next.taken        = i_taken_d;
    de_next.funct3       = funct3;
    de_next.alu_op       = alu_op_d;
    de_next.op_a_sel     = op_a_sel_d;
    de_next.op_b_sel     = op_b_sel_d;
    de_next.wb_sel       = wb_sel_d;
    de_next.reg_wr_en    = reg_wr_en_d;
    de_next.mem_rd_en    = mem_rd_en_d;
    de_next.mem_wr_en    = mem_wr_en_d;
    de_next.is_branch    = is_branch_d;
    de_next.is_jump      = is_jump_d;
    de_next.illegal      = illegal_d;
  end

  // Stall outranks flush so a held instruction is never lost to a bubble
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      de_reg <= '0;
    end else if (i_stall_e) begin
      de_reg <= de_reg;
    end else if (i_flush_e) begin
      de_reg <= '0;
    end else begin
      de_reg <= de_next;
    end
  end

  assign o_rs1_data_e     = de_reg.rs1_data;
  assign o_rs2_data_e     = de_reg.rs2_data;
  assign o_imm_e          = de_reg.imm;
  assign o_rs1_addr_e     = de_reg.rs1_addr;
  assign o_rs2_addr_e     = de_reg.rs2_addr;
  assign o_rd_e           = de_reg.rd;
  assign o_pc_e           = de_reg.pc;
  assign o_pc_four_e      = de_reg.pc_four;
  assign o_predicted_pc_e = de_reg.predicted_pc;
  assign o_taken_e        = de_reg.taken;
  assign o_funct3_e       = de_reg.funct3;
  assign o_alu_op_e       = de_reg.alu_op;
  assign o_op_a_sel_e     = de_reg.op_a_sel;
  assign o_op_b_sel_e     = de_reg.op_b_sel;
  assign o_wb_sel_e       = de_reg.wb_sel;
  assign o_reg_wr_en_e    = de_reg.reg_wr_en;
  assign o_mem_rd_en_e    = de_reg.mem_rd_en;
  assign o_mem_wr_en_e    = de_reg.mem_wr_en;
  assign o_is_branch_e    = de_reg.is_branch;
  assign o_is_jump_e      = de_reg.is_jump;
  assign o_illegal_e      = de_reg.illegal;

endmodule
